// File: rtl/boot_loader_pkg.sv
// Shared types and error codes for the data-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM} boot_state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/boot_loader.sv
// UART-fed boot loader: parses a framed image and writes little-endian words
// into the dmem8 banks through the boot port while holding debug high.
module boot_loader
  import boot_pkg::*;
#(
  parameter int          ADDR_W      = 13,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        debug,
  output logic        boot_we,
  output logic [31:0] boot_addr,
  output logic [31:0] boot_data,
  output logic        done,
  output logic [1:0]  err
);

  localparam int          TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  boot_state_t       state_q;
  logic [15:0]       len_q;
  logic [ADDR_W:0]   idx_q;
  logic [1:0]        lane_q;
  logic [31:0]       word_q;
  logic [7:0]        csum_q;
  logic [TW-1:0]     tmo_q;
  logic              debug_q, we_q, done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        err_q;

  logic [16:0] n_full;
  logic        last_word;
  logic        tmo_hit;

  assign n_full    = {1'b0, rx_data, len_q[7:0]};
  assign last_word = (17'(idx_q) + 17'd1) == {1'b0, len_q};
  // Counter holds the number of consecutive silent cycles inside a frame.
  assign tmo_hit   = (state_q != IDLE) && !rx_valid && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      debug_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= ERR_OK;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (state_q == IDLE || rx_valid) tmo_q <= '0;
      else                             tmo_q <= tmo_q + TW'(1);

      if (tmo_hit) begin
        err_q   <= ERR_TMO;
        done_q  <= 1'b1;
        debug_q <= 1'b0;
        state_q <= IDLE;
      end else if (rx_valid) begin
        case (state_q)
          IDLE: if (rx_data == SYNC_BYTE) begin
            err_q   <= ERR_OK;
            debug_q <= 1'b1;
            csum_q  <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            state_q <= LEN_LO;
          end
          LEN_LO: begin
            len_q[7:0] <= rx_data;
            state_q    <= LEN_HI;
          end
          LEN_HI: begin
            len_q[15:8] <= rx_data;
            if (n_full > CAP) begin
              err_q   <= ERR_LEN;
              done_q  <= 1'b1;
              debug_q <= 1'b0;
              state_q <= IDLE;
            end else if (n_full == 17'd0) begin
              state_q <= CSUM;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            csum_q <= csum_q ^ rx_data;
            word_q <= {rx_data, word_q[31:8]};
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              we_q   <= 1'b1;
              addr_q <= idx_q[ADDR_W-1:0];
              data_q <= {rx_data, word_q[31:8]};
              idx_q  <= idx_q + 1'b1;
              if (last_word) state_q <= CSUM;
            end
          end
          CSUM: begin
            done_q  <= 1'b1;
            debug_q <= 1'b0;
            err_q   <= (rx_data != csum_q) ? ERR_CSUM : ERR_OK;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign debug     = debug_q;
  assign boot_we   = we_q;
  assign boot_addr = 32'(addr_q);
  assign boot_data = data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized frame bench for boot_loader with a frame-level reference model.
module tb_boot_loader;
  localparam int         AW   = 13;
  localparam int         TMO  = 64;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         CAPW = 1 << AW;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        debug, boot_we, done;
  logic [31:0] boot_addr, boot_data;
  logic [1:0]  err;

  boot_loader #(.ADDR_W(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .debug(debug), .boot_we(boot_we), .boot_addr(boot_addr),
    .boot_data(boot_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
    logic        dbg;
  } wr_t;

  int   total = 0, bad = 0;
  int   cyc = 0, last_cyc = 0;
  wr_t  wr_q[$];
  int   done_n = 0, done_cyc = 0;
  logic done_dbg = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (boot_we) wr_q.push_back('{int'(boot_addr), boot_data, cyc, debug});
      if (done) begin
        done_n++;
        done_cyc = cyc;
        done_dbg = debug;
      end
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(logic [7:0] b, int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    last_cyc = cyc;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget && done_n == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  // Builds a frame from the format rules, sends it, and checks writes, err and done.
  task automatic run_frame(string tag, int n, bit badc, int maxgap, logic [7:0] fixed[$]);
    logic [7:0]  d[$];
    int          wc[$];
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] nn;
    logic [1:0]  eerr;
    int          nmis;
    cs = '0;
    nn = 16'(n);
    wr_q.delete();
    done_n = 0;
    put(SYNC, $urandom_range(maxgap, 0));
    put(nn[7:0], $urandom_range(maxgap, 0));
    put(nn[15:8], 0);
    if (n <= CAPW) begin
      for (int k = 0; k < 4 * n; k++) begin
        b = (fixed.size() > k) ? fixed[k] : 8'($urandom);
        d.push_back(b);
        cs ^= b;
        put(b, $urandom_range(maxgap, 0));
        if (k % 4 == 3) wc.push_back(last_cyc + 1);
      end
      put(badc ? ~cs : cs, 0);
    end
    idle();
    wait_done(20);
    eerr = (n > CAPW) ? 2'b10 : (badc ? 2'b01 : 2'b00);
    chk({tag, "_done_n"}, done_n, 1);
    chk({tag, "_err"}, err, eerr);
    chk({tag, "_done_lat"}, done_cyc, last_cyc + 1);
    chk({tag, "_done_dbg"}, done_dbg, 1'b0);
    chk({tag, "_wr_n"}, wr_q.size(), wc.size());
    nmis = 0;
    for (int i = 0; i < wr_q.size() && i < wc.size(); i++) begin
      if (wr_q[i].addr != i ||
          wr_q[i].data != {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]} ||
          wr_q[i].cyc != wc[i] || wr_q[i].dbg !== 1'b1) nmis++;
    end
    chk({tag, "_wr_mis"}, nmis, 0);
  endtask

  initial begin
    logic [7:0] none[$];
    logic [7:0] t1[$];
    int         dl;
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    repeat (3) @(negedge clk);
    chk("rst_debug", debug, 1'b0);
    chk("rst_we", boot_we, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 2'b00);
    chk("rst_addr", boot_addr, 32'h0);
    chk("rst_data", boot_data, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame("t1", 2, 1'b0, 2, t1);
    chk("t1_w0", (wr_q.size() > 0) ? wr_q[0].data : 32'hx, 32'h44332211);
    chk("t1_w1", (wr_q.size() > 1) ? wr_q[1].data : 32'hx, 32'h88776655);
    run_frame("t2", 2, 1'b1, 0, t1);
    chk("t2_debug_after", debug, 1'b0);
    run_frame("t3_zero", 0, 1'b0, 1, none);
    run_frame("t3_len", CAPW + 1, 1'b0, 1, none);

    repeat (10) @(negedge clk);
    chk("sticky_err", err, 2'b10);
    put(8'h3C, 0);
    idle();
    chk("sticky_3c", err, 2'b10);
    chk("idle_3c_dbg", debug, 1'b0);

    // Timeout: sync, N=2, only 6 data bytes.
    wr_q.delete();
    done_n = 0;
    put(SYNC, 0);
    idle();
    chk("sync_clr_err", err, 2'b00);
    chk("sync_dbg", debug, 1'b1);
    put(8'h02, 0);
    put(8'h00, 1);
    for (int k = 0; k < 6; k++) put(8'($urandom), $urandom_range(3, 0));
    idle();
    wait_done(TMO + 20);
    dl = done_cyc - last_cyc;
    chk("tmo_done_n", done_n, 1);
    chk("tmo_err", err, 2'b11);
    chk("tmo_wr_n", wr_q.size(), 1);
    chk("tmo_dbg", debug, 1'b0);
    chk("tmo_lat", (done_n == 1 && dl >= TMO && dl <= TMO + 2), 1'b1);

    put(8'h3C, 0);
    run_frame("t5", 1, 1'b0, 0, none);

    // Reset in the middle of DATA.
    put(SYNC, 0);
    put(8'h04, 0);
    put(8'h00, 0);
    for (int k = 0; k < 5; k++) put(8'($urandom), 0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("pre_rst_dbg", debug, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dbg", debug, 1'b0);
    chk("mid_rst_addr", boot_addr, 32'h0);
    chk("mid_rst_data", boot_data, 32'h0);
    chk("mid_rst_err", err, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    run_frame("t6", 3, 1'b0, 1, none);

    for (int f = 0; f < 12; f++) begin
      int n;
      n = (f % 5 == 4) ? CAPW + 1 + int'($urandom_range(300, 0)) : int'($urandom_range(6, 0));
      run_frame($sformatf("rnd%0d", f), n, ($urandom_range(2, 0) == 0), 3, none);
    end

    run_frame("cap", CAPW, 1'b0, 0, none);
    chk("cap_last_addr", (wr_q.size() > 0) ? wr_q[wr_q.size()-1].addr : -1, CAPW - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
